// File: rtl/backprop_pkg.sv
// Shared types and field layout for the backprop activation stash.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package backprop_pkg;

    localparam int SIZE      = 3;
    localparam int DATA_SIZE = 16;
    localparam int CTRL_W    = 66;

    // backprop_controll word: {valid, last, layer_idx[31:0], seq[31:0]}
    localparam int CTRL_VALID   = 65;
    localparam int CTRL_LAST    = 64;
    localparam int CTRL_IDX_MSB = 63;
    localparam int CTRL_SEQ_MSB = 31;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    function automatic logic [CTRL_W-1:0] pack_ctrl(
        input logic        valid,
        input logic        last,
        input logic [31:0] layer_idx,
        input logic [31:0] seq
    );
        logic [CTRL_W-1:0] w;
        w = '0;
        w[CTRL_VALID]               = valid;
        w[CTRL_LAST]                = last;
        w[CTRL_IDX_MSB -: 32]       = layer_idx;
        w[CTRL_SEQ_MSB -: 32]       = seq;
        return w;
    endfunction

endpackage

// File: rtl/z_stack_mem.sv
// Layer storage array: one write port, one registered read port.
// Latency: read data valid 1 cycle after rd_en; writes visible next cycle.
// Backpressure: none; caller guarantees addresses are in range.
module z_stack_mem #(
    parameter  int depth  = 8,
    parameter  int width  = 96,
    localparam int addr_w = $clog2(depth)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [addr_w-1:0] wr_addr,
    input  logic [width-1:0]  wr_dat,
    input  logic              rd_en,
    input  logic [addr_w-1:0] rd_addr,
    output logic [width-1:0]  rd_dat
);

    logic [width-1:0] mem [depth];

    // Array contents are deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/backprop_z_stack.sv
// LIFO stash of per-layer z / activation vectors, replayed last-layer-first for backprop.
// Latency: pop result registered 1 cycle after the accepting edge.
// Backpressure: push_ready low when full or draining; pops ignored unless draining.
module backprop_z_stack
    import backprop_pkg::*;
#(
    parameter  int size                   = SIZE,
    parameter  int data_size              = DATA_SIZE,
    parameter  int depth                  = 8,
    parameter  int backprop_controll_size = CTRL_W,
    localparam int bus_w                  = size * data_size,
    localparam int addr_w                 = $clog2(depth),
    localparam int cnt_w                  = addr_w + 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic                              push_valid,
    output logic                              push_ready,
    input  logic [bus_w-1:0]                  push_z,
    input  logic [bus_w-1:0]                  push_predict,
    input  logic                              drain_start,
    input  logic                              pop_req,
    output logic [bus_w-1:0]                  z_out,
    output logic [bus_w-1:0]                  predict_value_out,
    output logic [backprop_controll_size-1:0] backprop_controll_out,
    output logic [cnt_w-1:0]                  count,
    output logic                              state_drain
);

    localparam logic [cnt_w-1:0] CNT_ONE  = cnt_w'(1);
    localparam logic [cnt_w-1:0] CNT_FULL = cnt_w'(depth);

    state_t            state;
    logic [31:0]       seq;
    logic              push_acc;
    logic              pop_acc;
    logic [cnt_w-1:0]  count_m1;
    logic [31:0]       layer_idx;
    logic [2*bus_w-1:0] rd_dat;

    assign push_ready  = (state == S_FILL) && (count < CNT_FULL);
    assign state_drain = (state == S_DRAIN);
    assign push_acc    = push_valid && push_ready;
    assign pop_acc     = (state == S_DRAIN) && pop_req && (count != '0);
    assign count_m1    = count - CNT_ONE;
    assign layer_idx   = {{(32-cnt_w){1'b0}}, count_m1};

    // Memory side effects are suppressed whenever reset or clear wins the cycle.
    z_stack_mem #(
        .depth (depth),
        .width (2*bus_w)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push_acc && rst_n && !clear),
        .wr_addr (count[addr_w-1:0]),
        .wr_dat  ({push_predict, push_z}),
        .rd_en   (pop_acc && rst_n && !clear),
        .rd_addr (count_m1[addr_w-1:0]),
        .rd_dat  (rd_dat)
    );

    assign z_out             = rd_dat[bus_w-1:0];
    assign predict_value_out = rd_dat[2*bus_w-1:bus_w];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                 <= S_FILL;
            count                 <= '0;
            seq                   <= '0;
            backprop_controll_out <= '0;
        end else if (clear) begin
            state                             <= S_FILL;
            count                             <= '0;
            seq                               <= '0;
            backprop_controll_out[CTRL_VALID] <= 1'b0;
        end else begin
            // Valid is a one-cycle pulse; the other fields hold between pops.
            backprop_controll_out[CTRL_VALID] <= 1'b0;
            case (state)
                S_FILL: begin
                    if (push_acc) begin
                        count <= count + CNT_ONE;
                    end
                    // A push in the same cycle counts toward the non-empty check.
                    if (drain_start && ((count != '0) || push_acc)) begin
                        state <= S_DRAIN;
                        seq   <= '0;
                    end
                end
                S_DRAIN: begin
                    if (pop_acc) begin
                        count                 <= count_m1;
                        seq                   <= seq + 32'd1;
                        backprop_controll_out <= pack_ctrl(1'b1, count == CNT_ONE,
                                                           layer_idx, seq);
                        if (count == CNT_ONE) begin
                            state <= S_FILL;
                        end
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: doc/backprop_z_stack.md
Name: backprop_z_stack

Overview:
- Activation stash between the forward pass and the backprop pipeline.
- During the forward pass it captures per-layer z and predict_value vectors in push order.
- During backprop it replays them last-layer-first, one vector pair per pop, with a 66-bit backprop_controll word.
- Its outputs feed the backprop register stage directly. Values are Q8.8 signed fixed point; the block treats them as opaque bits.

Parameters:
size, 3, vector lanes per bus
data_size, 16, bits per lane
depth, 8, maximum stored layers (power of two, >=2)
backprop_controll_size, 66, control word width (1+1+32+32)

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
clear  in  1  synchronous flush: count:=0, state:=FILL
push_valid  in  1  forward pass offers a layer
push_ready  out  1  high in FILL when count<depth
push_z  in  size*data_size  layer pre-activation vector
push_predict  in  size*data_size  layer activation vector
drain_start  in  1  switch FILL->DRAIN
pop_req  in  1  backprop requests next layer
z_out  out  size*data_size  popped z
predict_value_out  out  size*data_size  popped activation
backprop_controll_out  out  66  {valid[65], last[64], layer_idx[63:32], seq[31:0]}
count  out  $clog2(depth)+1  stored entries
state_drain  out  1  1 in DRAIN

Behaviour:
- Reset (rst_n=0 at posedge): state FILL, count 0, seq counter 0, z_out/predict_value_out/backprop_controll_out all 0. push_ready follows state/count combinationally, so it reads 1 after reset. Reset overrides everything, including mid-drain; stored memory contents are not cleared.
- FSM FILL:
  - A push is accepted when push_valid & push_ready. It writes mem[count] and count+1.
  - pop_req is ignored.
  - drain_start with count>0 -> DRAIN, seq:=0. drain_start with count==0 is ignored and the state stays FILL.
- FSM DRAIN:
  - push_ready=0; pushes are not accepted.
  - pop_req with count>0 is accepted: reads mem[count-1] and count-1.
  - Next cycle, outputs are registered: z/predict from that entry; controll valid=1, layer_idx=count-1 (pre-decrement value), seq=seq, last=(count==1). seq increments.
  - Read latency is exactly 1 cycle from the accepting edge.
  - An accepted pop with last=1 returns the FSM to FILL on the same edge.
  - A pop cycle is single-cycle valid: in any cycle without an accepted pop, controll valid=0 (bit 65 cleared), while the data buses and the other controll fields hold their last values.
  - pop_req in DRAIN with count==0 is unreachable; defensively, no output and no state change.
- clear: acts like reset for state, count and seq, but z/predict buses hold; controll valid:=0. clear has priority over push, pop and drain_start in the same cycle.
- Simultaneous drain_start and push in FILL: the push is accepted first (count+1), then the state moves to DRAIN.
- drain_start while already in DRAIN is ignored.
- count never exceeds depth; a push at full is not accepted (push_ready=0) and the data is dropped by the producer protocol.
- Pointer arithmetic is unsigned, $clog2(depth)+1 bits; no wrap-around is possible.

Decomposition:
- Package backprop_pkg:
  - localparams for data_size, size, controll width;
  - controll field offsets CTRL_VALID=65, CTRL_LAST=64, CTRL_IDX_MSB=63, CTRL_SEQ_MSB=31;
  - state enum {S_FILL, S_DRAIN}.
- Sub-module z_stack_mem: depth x 2*size*data_size single-port-write / registered-read array, with write enable, write address, read enable and read address. The top level keeps the FSM, counters and control-word packing.

Test Plan:
- Reset then push three layers, z lanes = {1.0,2.0,3.0}*k (0x0100*k) for k=1..3 -> count=3, push_ready=1, all outputs 0.
- drain_start, then pop_req on 3 consecutive cycles -> z_out = layer3, layer2, layer1 on the following cycles; layer_idx=2,1,0; seq=0,1,2; last=0,0,1. After the third pop: state_drain=0, count=0.
- Fill to depth=8, then hold push_valid=1 -> push_ready=0, count stays 8. The 9th vector is never popped, and the first pop returns layer 8 (idx 7).
- drain_start with count=0 -> state_drain stays 0. A later pop_req produces controll valid=0.
- Mid-drain: push 4, pop 2, then assert clear -> count=0, FILL, controll valid=0 next cycle. A new push lands at idx 0.
- rst_n=0 for one cycle during DRAIN with an outstanding pop_req -> all outputs 0 and no pop result emitted. A subsequent push/drain sequence behaves as from reset.
